phy_tx_sched: RTL and testbench
===============================

Name: phy_tx_sched

Overview:
TX-side link controller and lane arbiter for the PHY. It sequences link bring-up: reset, comma training, then waiting for the far-end receiver to report `active`. Once the link is up, it round-robins two byte-wide requester lanes onto the single parallel-to-serial transmitter. It inserts the IDLE comma (0xBC) whenever no byte is granted. It sits in the clk_4f domain, between the lane sources and the parallel-to-serial block.

Parameters:
TRAIN_BC, 4, number of clk_4f cycles of forced IDLE transmitted in TRAIN before waiting on rx_active (1..15)
IDLE, 8'hBC, comma/idle byte driven on tx_data whenever tx_valid=0

Ports:
clk_4f  input  1  byte clock; all state on posedge
rst_L  input  1  asynchronous active-low reset
link_en  input  1  enables bring-up; low forces return to RESET state
rx_active  input  1  far-end receiver has locked on commas (active output of the serial-to-parallel receiver)
lane0_data  input  8  lane 0 byte
lane0_valid  input  1  lane 0 has a byte
lane0_ready  output  1  lane 0 byte accepted this cycle when lane0_valid & lane0_ready
lane1_data  input  8  lane 1 byte
lane1_valid  input  1  lane 1 has a byte
lane1_ready  output  1  lane 1 accept strobe
tx_data  output  8  byte to parallel-to-serial (registered)
tx_valid  output  1  tx_data carries payload (registered)
tx_lane  output  1  lane index of current tx_data; 0 when tx_valid=0
link_up  output  1  high in LINK state (registered)
state  output  2  0=RESET, 1=TRAIN, 2=WAIT_RX, 3=LINK
err_bc  output  1  sticky: a lane delivered a byte equal to IDLE

Behaviour:
- Reset is asynchronous and active-low (rst_L), single clock clk_4f.
- Reset values: tx_data=IDLE, tx_valid=0, tx_lane=0, link_up=0, state=RESET, err_bc=0, train counter=0, RR pointer=0 (lane 0 first).
- lane0_ready/lane1_ready are combinational from registered state, the pointer, the valids and rx_active. Both readies are 0 outside LINK.
- RESET: idle output. Next state is TRAIN if link_en=1, else stays in RESET.
- TRAIN:
  - Drives IDLE with tx_valid=0 and increments the train counter each cycle.
  - When the counter equals TRAIN_BC-1, moves to WAIT_RX and clears the counter. TRAIN therefore lasts exactly TRAIN_BC cycles.
- WAIT_RX: idle output. Moves to LINK on the first cycle with rx_active=1.
- LINK:
  - link_up=1 starting the cycle after entry.
  - Grant rule, evaluated only while rx_active=1:
    - If exactly one lane is valid, that lane's ready=1.
    - If both lanes are valid, the lane equal to the RR pointer gets ready=1; the other gets 0.
    - If neither lane is valid, both readies are 0.
  - At most one ready is high per cycle.
  - On a transfer (valid&ready), at the next posedge: tx_data=lane byte, tx_valid=1, tx_lane=granted index, RR pointer=the other lane.
  - With no transfer, the next cycle has tx_data=IDLE, tx_valid=0, tx_lane=0, and the pointer is unchanged.
  - Latency is exactly one cycle from accept to tx_data.
  - Full throughput: one byte per cycle, so back-to-back grants are allowed.
  - Both lanes continuously valid produces strict alternation 0,1,0,1...
- Link loss: if rx_active=0 in LINK, that cycle's readies are 0 and no transfer occurs. Next state is TRAIN, link_up goes 0, and the next tx_data is IDLE.
- Disable: link_en=0 in any state forces RESET at the next posedge. Readies are 0 in that cycle, and the next output is idle.
- Lane payload equal to IDLE is still forwarded with tx_valid=1, and err_bc sets the next cycle. err_bc clears only on rst_L.
- Reset mid-transfer: rst_L assertion immediately forces all reset values. An in-flight byte is dropped, with no partial output.
- state reflects the current registered state.

Test Plan:
- Bring-up, TRAIN_BC=4: release rst_L with link_en=1 and rx_active=0 → state goes RESET, TRAIN×4 cycles, WAIT_RX; tx_data=0xBC and tx_valid=0 throughout. Raise rx_active → state=3 and link_up=1 on the following cycle.
- Round-robin in LINK: both lanes valid with lane0 bytes 0x10,0x11 and lane1 bytes 0x20,0x21 → tx_data sequence 0x10,0x20,0x11,0x21 with tx_lane 0,1,0,1 and tx_valid=1 on four consecutive cycles.
- Single requester and gaps: lane1 only, byte 0x55, valid 1 cycle then 0 → one cycle of tx_data=0x55, tx_valid=1, tx_lane=1, then IDLE/0. The next contention grants lane 0 first.
- Link loss: drop rx_active while lane0_valid=1 in LINK → lane0_ready=0 that cycle, state=TRAIN next cycle, link_up=0, tx_data=0xBC. Retraining lasts 4 cycles before WAIT_RX.
- Error and disable: lane0 sends 0xBC in LINK → forwarded with tx_valid=1, err_bc=1 next cycle and held. Then link_en=0 → state=RESET, err_bc stays 1 until rst_L pulse clears it.
- Async reset mid-stream: assert rst_L between clock edges during back-to-back transfers → outputs go to reset values immediately without waiting for a clock edge.

Source files
------------

// File: rtl/phy_tx_sched.sv
// TX link controller: RESET/TRAIN/WAIT_RX/LINK bring-up sequencing plus a two-lane
// round-robin byte arbiter feeding the parallel-to-serial transmitter, with IDLE fill.
module phy_tx_sched #(
    parameter int unsigned TRAIN_BC = 4,
    parameter logic [7:0]  IDLE     = 8'hBC
) (
    input  logic       clk_4f,
    input  logic       rst_L,
    input  logic       link_en,
    input  logic       rx_active,
    input  logic [7:0] lane0_data,
    input  logic       lane0_valid,
    output logic       lane0_ready,
    input  logic [7:0] lane1_data,
    input  logic       lane1_valid,
    output logic       lane1_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_lane,
    output logic       link_up,
    output logic [1:0] state,
    output logic       err_bc
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_TRAIN   = 2'd1,
        ST_WAIT_RX = 2'd2,
        ST_LINK    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ptr;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic               r_tx_lane;
    logic               r_link_up;
    logic               r_err_bc;

    logic               w_arb_en;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_xfer;
    logic [7:0]         w_xfer_data;

    // Arbitration only while the link is up, enabled and the far end is still locked.
    assign w_arb_en    = (r_state == ST_LINK) && link_en && rx_active;
    assign w_gnt0      = w_arb_en && lane0_valid && (!lane1_valid || (r_ptr == 1'b0));
    assign w_gnt1      = w_arb_en && lane1_valid && (!lane0_valid || (r_ptr == 1'b1));
    assign w_xfer      = w_gnt0 || w_gnt1;
    assign w_xfer_data = w_gnt1 ? lane1_data : lane0_data;

    assign lane0_ready = w_gnt0;
    assign lane1_ready = w_gnt1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_TRAIN;
            end
            ST_TRAIN: begin
                if (r_cnt == CNT_W'(TRAIN_BC - 1)) begin
                    w_state_nxt = ST_WAIT_RX;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_RX: begin
                if (rx_active) begin
                    w_state_nxt = ST_LINK;
                end
            end
            ST_LINK: begin
                if (!rx_active) begin
                    w_state_nxt = ST_TRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
        if (!link_en) begin
            w_state_nxt = ST_RESET;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk_4f or negedge rst_L) begin
        if (!rst_L) begin
            r_state    <= ST_RESET;
            r_cnt      <= '0;
            r_ptr      <= 1'b0;
            r_tx_data  <= IDLE;
            r_tx_valid <= 1'b0;
            r_tx_lane  <= 1'b0;
            r_link_up  <= 1'b0;
            r_err_bc   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_link_up  <= (w_state_nxt == ST_LINK);
            r_tx_valid <= w_xfer;
            r_tx_data  <= w_xfer ? w_xfer_data : IDLE;
            r_tx_lane  <= w_gnt1;
            if (w_gnt0) begin
                r_ptr <= 1'b1;
            end else if (w_gnt1) begin
                r_ptr <= 1'b0;
            end
            // Payload equal to the comma is still forwarded but flagged until reset.
            if (w_xfer && (w_xfer_data == IDLE)) begin
                r_err_bc <= 1'b1;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_lane  = r_tx_lane;
    assign link_up  = r_link_up;
    assign state    = r_state;
    assign err_bc   = r_err_bc;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed vector bench for phy_tx_sched: bring-up, round-robin, link loss, comma error,
// disable and asynchronous reset.
module tb_phy_tx_sched;

    logic       clk_4f;
    logic       rst_L;
    logic       link_en;
    logic       rx_active;
    logic [7:0] lane0_data;
    logic       lane0_valid;
    logic       lane0_ready;
    logic [7:0] lane1_data;
    logic       lane1_valid;
    logic       lane1_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_lane;
    logic       link_up;
    logic [1:0] state;
    logic       err_bc;

    int n_checks = 0;
    int n_errors = 0;

    phy_tx_sched #(.TRAIN_BC(4), .IDLE(8'hBC)) dut (
        .clk_4f      (clk_4f),
        .rst_L       (rst_L),
        .link_en     (link_en),
        .rx_active   (rx_active),
        .lane0_data  (lane0_data),
        .lane0_valid (lane0_valid),
        .lane0_ready (lane0_ready),
        .lane1_data  (lane1_data),
        .lane1_valid (lane1_valid),
        .lane1_ready (lane1_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_lane     (tx_lane),
        .link_up     (link_up),
        .state       (state),
        .err_bc      (err_bc)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic       en;
        logic       rx;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic [1:0] st;
        logic [7:0] td;
        logic       tv;
        logic       tl;
        logic       up;
        logic       err;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mk(logic en, logic rx, logic v0, logic [7:0] d0, logic v1,
                                logic [7:0] d1, logic r0, logic r1, logic [1:0] st,
                                logic [7:0] td, logic tv, logic tl, logic up, logic err);
        vec_t v;
        v.en = en; v.rx = rx; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.st = st; v.td = td; v.tv = tv; v.tl = tl;
        v.up = up; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rx, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1);
        link_en = en; rx_active = rx;
        lane0_valid = v0; lane0_data = d0;
        lane1_valid = v1; lane1_data = d1;
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_tx_data"}, 0, tx_data, 8'hBC);
        chk({tag, "_tx_valid"}, 0, 8'(tx_valid), 8'd0);
        chk({tag, "_tx_lane"}, 0, 8'(tx_lane), 8'd0);
        chk({tag, "_link_up"}, 0, 8'(link_up), 8'd0);
        chk({tag, "_state"}, 0, 8'(state), 8'd0);
    endtask

    // Bring the link up with rx_active held high; bounded so a stuck FSM cannot hang the run.
    task automatic bring_up(input string tag);
        bit up_seen = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 20 && !up_seen; i++) begin
            @(posedge clk_4f); #1;
            if (state == 2'd3) up_seen = 1'b1;
        end
        chk({tag, "_link_reached"}, 0, 8'(up_seen), 8'd1);
    endtask

    initial begin
        // Expected readies apply to the cycle itself; the rest are sampled after its posedge.
        vecs[0]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd1, 8'hBC, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd1, 8'hBC, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd1, 8'hBC, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd1, 8'hBC, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd2, 8'hBC, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd2, 8'hBC, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 1, 8'h10, 1, 8'h20, 0, 0, 2'd3, 8'hBC, 0, 0, 1, 0);
        vecs[7]  = mk(1, 1, 1, 8'h10, 1, 8'h20, 1, 0, 2'd3, 8'h10, 1, 0, 1, 0);
        vecs[8]  = mk(1, 1, 1, 8'h11, 1, 8'h20, 0, 1, 2'd3, 8'h20, 1, 1, 1, 0);
        vecs[9]  = mk(1, 1, 1, 8'h11, 1, 8'h21, 1, 0, 2'd3, 8'h11, 1, 0, 1, 0);
        vecs[10] = mk(1, 1, 1, 8'h12, 1, 8'h21, 0, 1, 2'd3, 8'h21, 1, 1, 1, 0);
        vecs[11] = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 2'd3, 8'hBC, 0, 0, 1, 0);
        vecs[12] = mk(1, 1, 0, 8'h00, 1, 8'h55, 0, 1, 2'd3, 8'h55, 1, 1, 1, 0);
        vecs[13] = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 2'd3, 8'hBC, 0, 0, 1, 0);
        vecs[14] = mk(1, 1, 1, 8'h30, 1, 8'h40, 1, 0, 2'd3, 8'h30, 1, 0, 1, 0);
        vecs[15] = mk(1, 1, 1, 8'hBC, 0, 8'h00, 1, 0, 2'd3, 8'hBC, 1, 0, 1, 1);
        vecs[16] = mk(1, 0, 1, 8'h01, 0, 8'h00, 0, 0, 2'd1, 8'hBC, 0, 0, 0, 1);
        vecs[17] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd1, 8'hBC, 0, 0, 0, 1);
        vecs[18] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd1, 8'hBC, 0, 0, 0, 1);
        vecs[19] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd1, 8'hBC, 0, 0, 0, 1);
        vecs[20] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd2, 8'hBC, 0, 0, 0, 1);
        vecs[21] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 2'd0, 8'hBC, 0, 0, 0, 1);
        vecs[22] = mk(0, 1, 1, 8'h07, 1, 8'h08, 0, 0, 2'd0, 8'hBC, 0, 0, 0, 1);

        rst_L = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) @(posedge clk_4f);
        #1;
        check_idle_reset("rst");
        chk("rst_err_bc", 0, 8'(err_bc), 8'd0);

        @(negedge clk_4f);
        rst_L = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk_4f);
            drive(vecs[i].en, vecs[i].rx, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            #1;
            chk("lane0_ready", i, 8'(lane0_ready), 8'(vecs[i].r0));
            chk("lane1_ready", i, 8'(lane1_ready), 8'(vecs[i].r1));
            @(posedge clk_4f); #1;
            chk("state", i, 8'(state), 8'(vecs[i].st));
            chk("tx_data", i, tx_data, vecs[i].td);
            chk("tx_valid", i, 8'(tx_valid), 8'(vecs[i].tv));
            chk("tx_lane", i, 8'(tx_lane), 8'(vecs[i].tl));
            chk("link_up", i, 8'(link_up), 8'(vecs[i].up));
            chk("err_bc", i, 8'(err_bc), 8'(vecs[i].err));
        end

        // Sticky comma error clears only on reset.
        @(negedge clk_4f);
        rst_L = 1'b0;
        #1;
        chk("err_clear", 0, 8'(err_bc), 8'd0);
        @(negedge clk_4f);
        rst_L = 1'b1;

        // Disable while in LINK with a pending byte: no grant, back to RESET.
        bring_up("dis");
        chk("dis_link_up", 0, 8'(link_up), 8'd1);
        @(negedge clk_4f);
        drive(1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00);
        #1;
        chk("dis_ready0", 0, 8'(lane0_ready), 8'd0);
        @(posedge clk_4f); #1;
        check_idle_reset("dis");

        // Async reset between edges while transfers are streaming.
        bring_up("arst");
        @(negedge clk_4f);
        drive(1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 8'hB2);
        @(posedge clk_4f); #1;
        chk("arst_inflight_valid", 0, 8'(tx_valid), 8'd1);
        #2;
        rst_L = 1'b0;
        #1;
        check_idle_reset("arst");
        chk("arst_ready0", 0, 8'(lane0_ready), 8'd0);
        chk("arst_ready1", 0, 8'(lane1_ready), 8'd0);
        @(negedge clk_4f);
        rst_L = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
